core_sram_arbiter: RTL and testbench

- Shares port A of the dual-port core SRAM between two requesters: requester 0 is instruction fetch, requester 1 is load/store.
- Round-robin grant, one transfer per cycle, valid/ready request handshake.
- Read responses are routed back to the originating requester, tracking the SRAM's one-cycle read latency.
- Sits between the core pipeline and the SRAM; port B of the SRAM stays with the debug/loader path and is outside this block.

---
 rtl/core_sram_pkg.sv | 16 +
 rtl/core_sram_arbiter_if.sv | 26 ++
 rtl/core_rr_arb2.sv | 59 +++++
 rtl/core_sram_arbiter.sv | 67 ++++++
 tb/tb_core_sram_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_sram_pkg.sv
// Shared widths and request struct for the core SRAM port-A arbiter.
// Optional feature macro: CORE_SRAM_ARB_LOCK_EN (see core_rr_arb2 / core_sram_arbiter).
package core_sram_pkg;

    localparam int unsigned ADDRWIDTH    = 14;
    localparam int unsigned DATAWIDTH    = 32;
    localparam int unsigned BYTE_ENABLES = DATAWIDTH / 8;

    typedef struct packed {
        logic [ADDRWIDTH-1:0]    addr;
        logic                    we;
        logic [BYTE_ENABLES-1:0] be;
        logic [DATAWIDTH-1:0]    wdata;
    } sram_req_t;

endpackage

// File: rtl/core_sram_arbiter_if.sv
// One requester's request/response bundle toward the SRAM arbiter.
// The lock signal exists only when CORE_SRAM_ARB_LOCK_EN is defined.
interface core_sram_arbiter_if;
    import core_sram_pkg::*;

    logic                    valid;
    logic                    ready;
    logic [ADDRWIDTH-1:0]    addr;
    logic                    we;
    logic [BYTE_ENABLES-1:0] be;
    logic [DATAWIDTH-1:0]    wdata;
`ifdef CORE_SRAM_ARB_LOCK_EN
    logic                    lock;
`endif
    logic                    rsp_valid;
    logic [DATAWIDTH-1:0]    rsp_rdata;

`ifdef CORE_SRAM_ARB_LOCK_EN
    modport master (output valid, addr, we, be, wdata, lock, input ready, rsp_valid, rsp_rdata);
    modport slave  (input valid, addr, we, be, wdata, lock, output ready, rsp_valid, rsp_rdata);
`else
    modport master (output valid, addr, we, be, wdata, input ready, rsp_valid, rsp_rdata);
    modport slave  (input valid, addr, we, be, wdata, output ready, rsp_valid, rsp_rdata);
`endif

endinterface

// File: rtl/core_rr_arb2.sv
// Two-input round-robin grant with last_grant history and optional lock (CORE_SRAM_ARB_LOCK_EN).
// ready is combinational from valid and forced low while rst is high.
module core_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
`ifdef CORE_SRAM_ARB_LOCK_EN
    input  logic [1:0] lock,
`endif
    output logic [1:0] ready,
    output logic       accepted
);

    logic last_grant_q, last_grant_d;
    logic gnt1;
`ifdef CORE_SRAM_ARB_LOCK_EN
    logic lock_q, lock_d;
`endif

    always_comb begin
        gnt1 = 1'b0;
        if (valid[0] && valid[1]) begin
            gnt1 = ~last_grant_q;
        end else begin
            gnt1 = valid[1];
        end
`ifdef CORE_SRAM_ARB_LOCK_EN
        // The locking transfer also set last_grant, so it names the owner.
        if (lock_q) begin
            gnt1 = last_grant_q;
        end
`endif
        ready = 2'b00;
        if (!rst) begin
            ready[0] = valid[0] && !gnt1;
            ready[1] = valid[1] && gnt1;
        end
        accepted     = |ready;
        last_grant_d = accepted ? ready[1] : last_grant_q;
`ifdef CORE_SRAM_ARB_LOCK_EN
        lock_d = accepted ? lock[ready[1]] : lock_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
`ifdef CORE_SRAM_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
`ifdef CORE_SRAM_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

endmodule

// File: rtl/core_sram_arbiter.sv
// Shares SRAM port A between instruction fetch (req0) and load/store (req1); routes 1-cycle reads.
// Optional grant locking for RMW sequences under CORE_SRAM_ARB_LOCK_EN.
module core_sram_arbiter
    import core_sram_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    core_sram_arbiter_if.slave      req0,
    core_sram_arbiter_if.slave      req1,
    output logic [ADDRWIDTH-1:0]    sram_addr,
    output logic                    sram_we,
    output logic [BYTE_ENABLES-1:0] sram_be,
    output logic [DATAWIDTH-1:0]    sram_d,
    input  logic [DATAWIDTH-1:0]    sram_q
);

    logic [1:0] ready;
    logic       accepted;
    sram_req_t  sel;
    logic       rsp_pending_q, rsp_pending_d;
    logic       rsp_owner_q, rsp_owner_d;

    core_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    ({req1.valid, req0.valid}),
`ifdef CORE_SRAM_ARB_LOCK_EN
        .lock     ({req1.lock, req0.lock}),
`endif
        .ready    (ready),
        .accepted (accepted)
    );

    assign req0.ready = ready[0];
    assign req1.ready = ready[1];

    always_comb begin
        // Requester 0 is the idle default; harmless since we/be are gated off.
        sel = '{addr: req0.addr, we: req0.we, be: req0.be, wdata: req0.wdata};
        if (ready[1]) begin
            sel = '{addr: req1.addr, we: req1.we, be: req1.be, wdata: req1.wdata};
        end
        sram_addr = sel.addr;
        sram_d    = sel.wdata;
        sram_we   = sel.we && accepted;
        sram_be   = accepted ? sel.be : '0;

        rsp_pending_d = accepted && !sel.we;
        rsp_owner_d   = accepted ? ready[1] : rsp_owner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= 1'b0;
        end else begin
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
        end
    end

    assign req0.rsp_valid = rsp_pending_q && (rsp_owner_q == 1'b0);
    assign req1.rsp_valid = rsp_pending_q && (rsp_owner_q == 1'b1);
    assign req0.rsp_rdata = sram_q;
    assign req1.rsp_rdata = sram_q;

endmodule

// File: tb/tb_core_sram_arbiter.sv
// Directed bench for core_sram_arbiter with a behavioural SRAM; lock steps under CORE_SRAM_ARB_LOCK_EN.
module tb_core_sram_arbiter;
    import core_sram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [ADDRWIDTH-1:0]    sram_addr;
    logic                    sram_we;
    logic [BYTE_ENABLES-1:0] sram_be;
    logic [DATAWIDTH-1:0]    sram_d;
    logic [DATAWIDTH-1:0]    sram_q;
    logic [DATAWIDTH-1:0]    mem [0:(1<<ADDRWIDTH)-1];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    core_sram_arbiter_if r0 ();
    core_sram_arbiter_if r1 ();

    core_sram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (r0),
        .req1      (r1),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_be   (sram_be),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 clk = ~clk;

    // Read-before-write SRAM with one-cycle read latency.
    always @(posedge clk) begin
        sram_q <= mem[sram_addr];
        if (sram_we) begin
            for (int b = 0; b < BYTE_ENABLES; b++) begin
                if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_d[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [13:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] d);
        r0.valid = v; r0.addr = a; r0.we = we; r0.be = be; r0.wdata = d;
    endtask

    task automatic drv1(input logic v, input logic [13:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] d);
        r1.valid = v; r1.addr = a; r1.we = we; r1.be = be; r1.wdata = d;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDRWIDTH); i++) mem[i] = 32'hC0DE0000 | i;
`ifdef CORE_SRAM_ARB_LOCK_EN
        r0.lock = 1'b0;
        r1.lock = 1'b0;
`endif
        rst = 1'b1;
        drv0(1'b1, 14'h10, 1'b0, 4'h0, 32'h0);
        drv1(1'b1, 14'h20, 1'b0, 4'h0, 32'h0);

        // Reset holds everything quiet even with both requesters valid.
        @(negedge clk);
        chk("rst_ready0", r0.ready, 0);
        chk("rst_ready1", r1.ready, 0);
        chk("rst_rsp0", r0.rsp_valid, 0);
        chk("rst_rsp1", r1.rsp_valid, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_be", sram_be, 0);

        // Single read from req0 at 0x10.
        step();
        rst = 1'b0;
        r1.valid = 1'b0;
        @(negedge clk);
        chk("rd0_ready0", r0.ready, 1);
        chk("rd0_ready1", r1.ready, 0);
        chk("rd0_addr", sram_addr, 14'h10);

        // req1 write lands in the response cycle of req0's read.
        step();
        drv0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        drv1(1'b1, 14'h20, 1'b1, 4'b0011, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd0_rsp_valid", r0.rsp_valid, 1);
        chk("rd0_rsp_data", r0.rsp_rdata, 32'hC0DE0010);
        chk("wr1_ready1", r1.ready, 1);
        chk("wr1_sram_we", sram_we, 1);
        chk("wr1_sram_be", sram_be, 4'b0011);

        // Read back 0x20; the write must not produce a response.
        step();
        drv1(1'b1, 14'h20, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("wr1_no_rsp0", r0.rsp_valid, 0);
        chk("wr1_no_rsp1", r1.rsp_valid, 0);
        chk("rd1_ready1", r1.ready, 1);

        // Contention: req0 reads 0x1, req1 reads 0x2, held for 4 cycles.
        step();
        drv0(1'b1, 14'h1, 1'b0, 4'h0, 32'h0);
        drv1(1'b1, 14'h2, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rd1_rsp_valid", r1.rsp_valid, 1);
        chk("rd1_rsp_data", r1.rsp_rdata, 32'hC0DEBEEF);
        chk("c0_ready0", r0.ready, 1);
        chk("c0_ready1", r1.ready, 0);
        chk("c0_addr", sram_addr, 14'h1);

        step();
        @(negedge clk);
        chk("c1_ready0", r0.ready, 0);
        chk("c1_ready1", r1.ready, 1);
        chk("c1_addr_stall", sram_addr, 14'h2);
        chk("c1_rsp0", r0.rsp_valid, 1);
        chk("c1_rsp1", r1.rsp_valid, 0);
        chk("c1_data", r0.rsp_rdata, 32'hC0DE0001);

        step();
        @(negedge clk);
        chk("c2_ready0", r0.ready, 1);
        chk("c2_ready1", r1.ready, 0);
        chk("c2_rsp1", r1.rsp_valid, 1);
        chk("c2_data", r1.rsp_rdata, 32'hC0DE0002);

        step();
        @(negedge clk);
        chk("c3_ready0", r0.ready, 0);
        chk("c3_ready1", r1.ready, 1);
        chk("c3_rsp0", r0.rsp_valid, 1);
        chk("c3_data", r0.rsp_rdata, 32'hC0DE0001);

        step();
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        @(negedge clk);
        chk("c4_rsp1", r1.rsp_valid, 1);
        chk("c4_rsp0", r0.rsp_valid, 0);
        chk("c4_data", r1.rsp_rdata, 32'hC0DE0002);
        chk("idle_we", sram_we, 0);
        chk("idle_be", sram_be, 0);

        // Reset mid-read: the pending response is dropped.
        step();
        drv0(1'b1, 14'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("mr_ready0", r0.ready, 1);
        step();
        rst = 1'b1;
        r0.valid = 1'b0;
        @(negedge clk);
        chk("mr_rsp0", r0.rsp_valid, 0);
        chk("mr_rsp1", r1.rsp_valid, 0);

        // After reset last_grant is 1 again, so req0 wins contention.
        step();
        rst = 1'b0;
        drv0(1'b1, 14'h1, 1'b0, 4'h0, 32'h0);
        drv1(1'b1, 14'h2, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("mr_post_ready0", r0.ready, 1);
        chk("mr_post_ready1", r1.ready, 0);
        chk("mr_post_rsp0", r0.rsp_valid, 0);

`ifdef CORE_SRAM_ARB_LOCK_EN
        // req1 locks for a read, then a write with lock released; req0 stays valid.
        step();
        r1.lock = 1'b1;
        @(negedge clk);
        chk("lk0_rsp0", r0.rsp_valid, 1);
        chk("lk0_data", r0.rsp_rdata, 32'hC0DE0001);
        chk("lk0_ready1", r1.ready, 1);
        chk("lk0_ready0", r0.ready, 0);

        step();
        drv1(1'b1, 14'h30, 1'b1, 4'hF, 32'h12345678);
        r1.lock = 1'b0;
        @(negedge clk);
        chk("lk1_ready1", r1.ready, 1);
        chk("lk1_ready0", r0.ready, 0);
        chk("lk1_we", sram_we, 1);
        chk("lk1_rsp1", r1.rsp_valid, 1);

        step();
        r1.valid = 1'b0;
        @(negedge clk);
        chk("lk2_ready0", r0.ready, 1);
        chk("lk2_rsp1", r1.rsp_valid, 0);
        step();
        r0.valid = 1'b0;
`else
        step();
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        @(negedge clk);
        chk("tail_rsp0", r0.rsp_valid, 1);
        chk("tail_data", r0.rsp_rdata, 32'hC0DE0001);
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
